// File: rtl/trace_pkg.sv
// Shared types and constants for the retire-trace arbiter slice.
package trace_pkg;

    localparam int unsigned XLEN    = 32;
    // Storage width for sequence numbers; instances use the low SEQ_W bits.
    localparam int unsigned SEQ_MAX = 32;

    typedef struct packed {
        logic [XLEN-1:0]    hartid;
        logic [XLEN-1:0]    timer;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    inst;
        logic [XLEN-1:0]    wrdata;
        logic [4:0]         wrdst;
        logic               wren;
        logic               slot;
        logic [SEQ_MAX-1:0] seq;
    } trace_rec_t;

    // Number of records offered by the core in one cycle.
    function automatic logic [1:0] slot_count(input logic en, input logic v0, input logic v1);
        return en ? ({1'b0, v0} + {1'b0, v1}) : 2'd0;
    endfunction

endpackage

// File: rtl/retire_trace_arbiter_if.sv
// Retire-trace taps in, buffered trace stream and status out.
interface retire_trace_arbiter_if
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SEQ_W  = 16,
    parameter int unsigned DROP_W = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              trace_en;
    logic [XLEN-1:0]   hartid;
    logic [XLEN-1:0]   timer;
    logic              s0_valid;
    logic [XLEN-1:0]   s0_pc;
    logic [XLEN-1:0]   s0_inst;
    logic              s0_wren;
    logic [4:0]        s0_wrdst;
    logic [XLEN-1:0]   s0_wrdata;
    logic              s1_valid;
    logic [XLEN-1:0]   s1_pc;
    logic [XLEN-1:0]   s1_inst;
    logic              s1_wren;
    logic [4:0]        s1_wrdst;
    logic [XLEN-1:0]   s1_wrdata;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_hartid;
    logic [XLEN-1:0]   out_timer;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_inst;
    logic [XLEN-1:0]   out_wrdata;
    logic              out_wren;
    logic [4:0]        out_wrdst;
    logic              out_slot;
    logic [SEQ_W-1:0]  out_seq;
    logic [DROP_W-1:0] drop_count;
    logic              overflow;
    logic [LVL_W-1:0]  level;

    modport master (
        output trace_en, hartid, timer,
               s0_valid, s0_pc, s0_inst, s0_wren, s0_wrdst, s0_wrdata,
               s1_valid, s1_pc, s1_inst, s1_wren, s1_wrdst, s1_wrdata,
               out_ready,
        input  out_valid, out_hartid, out_timer, out_pc, out_inst, out_wrdata,
               out_wren, out_wrdst, out_slot, out_seq, drop_count, overflow, level
    );

    modport slave (
        input  trace_en, hartid, timer,
               s0_valid, s0_pc, s0_inst, s0_wren, s0_wrdst, s0_wrdata,
               s1_valid, s1_pc, s1_inst, s1_wren, s1_wrdst, s1_wrdata,
               out_ready,
        output out_valid, out_hartid, out_timer, out_pc, out_inst, out_wrdata,
               out_wren, out_wrdst, out_slot, out_seq, drop_count, overflow, level
    );

endinterface

// File: rtl/trace_fifo2w.sv
// DEPTH-entry record FIFO with two write ports and one read port.
// The caller guarantees wr_cnt never exceeds free space and rd_en only when non-empty.
module trace_fifo2w
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       wr_cnt,
    input  trace_rec_t       wr_data [2],
    input  logic             rd_en,
    output logic [LVL_W-1:0] level,
    output trace_rec_t       head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    trace_rec_t       mem_q [DEPTH];
    trace_rec_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    // Write up to two records in order, advance pointers, update occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_nx = wr_ptr_q + PTR_W'(1);
        wr_ptr_d  = wr_ptr_q + PTR_W'(wr_cnt);
        rd_ptr_d  = rd_ptr_q + PTR_W'(rd_en);
        level_d   = level_q + LVL_W'(wr_cnt) - LVL_W'(rd_en);
        if (wr_cnt != 2'd0) begin
            mem_d[wr_ptr_q] = wr_data[0];
        end
        if (wr_cnt == 2'd2) begin
            mem_d[wr_ptr_nx] = wr_data[1];
        end
    end

    // Storage and pointer registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/retire_trace_arbiter.sv
// Merges the two retire-trace slots into one in-order, sequence-tagged stream.
// Cycles that do not fit in the FIFO are dropped whole and counted.
module retire_trace_arbiter
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SEQ_W  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    retire_trace_arbiter_if.slave  bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [SEQ_W-1:0]  next_seq_q, next_seq_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic              overflow_q, overflow_d;

    logic [1:0]        push_n;
    logic [1:0]        wr_cnt;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  free_slots;
    logic              drop;
    logic              pop;
    trace_rec_t        rec0, rec1, head;
    trace_rec_t        wr_data [2];
    logic              unused_seq_hi;

    // Build both slot records; a lone slot 1 is compacted onto write port 0.
    always_comb begin
        rec0        = '0;
        rec0.hartid = bus.hartid;
        rec0.timer  = bus.timer;
        rec0.pc     = bus.s0_pc;
        rec0.inst   = bus.s0_inst;
        rec0.wrdata = bus.s0_wrdata;
        rec0.wrdst  = bus.s0_wrdst;
        rec0.wren   = bus.s0_wren;
        rec0.slot   = 1'b0;
        rec0.seq    = SEQ_MAX'(next_seq_q);

        rec1        = '0;
        rec1.hartid = bus.hartid;
        rec1.timer  = bus.timer;
        rec1.pc     = bus.s1_pc;
        rec1.inst   = bus.s1_inst;
        rec1.wrdata = bus.s1_wrdata;
        rec1.wrdst  = bus.s1_wrdst;
        rec1.wren   = bus.s1_wren;
        rec1.slot   = 1'b1;
        rec1.seq    = SEQ_MAX'(next_seq_q + SEQ_W'(bus.s0_valid));

        wr_data[0]  = bus.s0_valid ? rec0 : rec1;
        wr_data[1]  = rec1;
    end

    // Drop decision uses pre-pop occupancy; sequence advances even on drops.
    always_comb begin
        push_n       = slot_count(bus.trace_en, bus.s0_valid, bus.s1_valid);
        free_slots   = LVL_W'(DEPTH) - level;
        drop         = LVL_W'(push_n) > free_slots;
        wr_cnt       = drop ? 2'd0 : push_n;
        pop          = (level != '0) && bus.out_ready;
        next_seq_d   = next_seq_q + SEQ_W'(push_n);
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (drop) begin
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + DROP_W'(1);
            end
            overflow_d = 1'b1;
        end
    end

    // Sequence and drop-accounting registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            next_seq_q   <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            next_seq_q   <= next_seq_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    trace_fifo2w #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_cnt  (wr_cnt),
        .wr_data (wr_data),
        .rd_en   (pop),
        .level   (level),
        .head    (head)
    );

    assign unused_seq_hi  = |(head.seq >> SEQ_W);

    assign bus.out_valid  = (level != '0);
    assign bus.out_hartid = head.hartid;
    assign bus.out_timer  = head.timer;
    assign bus.out_pc     = head.pc;
    assign bus.out_inst   = head.inst;
    assign bus.out_wrdata = head.wrdata;
    assign bus.out_wren   = head.wren;
    assign bus.out_wrdst  = head.wrdst;
    assign bus.out_slot   = head.slot;
    assign bus.out_seq    = head.seq[SEQ_W-1:0];
    assign bus.drop_count = drop_count_q;
    assign bus.overflow   = overflow_q;
    assign bus.level      = level;

endmodule
